// File: rtl/aq_alu_pkg.sv
// Shared opcode encoding and default widths for the aq_alu leaf ALU.
package aq_alu_pkg;

    localparam int IN_W_DEF  = 2;
    localparam int OUT_W_DEF = 8;

    typedef enum logic [3:0] {
        OP_ADD     = 4'b0000,
        OP_SUB     = 4'b0001,
        OP_MUL     = 4'b0010,
        OP_DIV     = 4'b0011,
        OP_MOD     = 4'b0100,
        OP_AND     = 4'b0101,
        OP_OR      = 4'b0110,
        OP_XOR     = 4'b0111,
        OP_NAND    = 4'b1000,
        OP_NOR     = 4'b1001,
        OP_XNOR    = 4'b1010,
        OP_SHL     = 4'b1011,
        OP_SHR     = 4'b1100,
        OP_CMP     = 4'b1101,
        OP_ACC_RD  = 4'b1110,
        OP_ACC_MAC = 4'b1111
    } op_e;

endpackage

// File: rtl/aq_alu_if.sv
// Operand/opcode/result bundle between a requester and the aq_alu datapath.
interface aq_alu_if
    import aq_alu_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);
    logic [IN_W-1:0]  A;
    logic [IN_W-1:0]  B;
    logic [3:0]       Opcode;
    logic [OUT_W-1:0] Output;

    modport master (output A, output B, output Opcode, input  Output);
    modport slave  (input  A, input  B, input  Opcode, output Output);
endinterface

// File: rtl/aq_alu_acc.sv
// Accumulator register with async active-low clear; wraps by default,
// saturates at all-ones when AQ_ALU_ACC_SAT_EN is defined.
module aq_alu_acc
    import aq_alu_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [OUT_W-1:0] addend,
    output logic [OUT_W-1:0] acc_o
);
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_d;
`ifdef AQ_ALU_ACC_SAT_EN
    logic [OUT_W:0]   sum;
`else
    logic [OUT_W-1:0] sum;
`endif

    always_comb begin
`ifdef AQ_ALU_ACC_SAT_EN
        sum   = {1'b0, acc_q} + {1'b0, addend};
        acc_d = acc_q;
        if (en) acc_d = sum[OUT_W] ? '1 : sum[OUT_W-1:0];
`else
        sum   = acc_q + addend;
        acc_d = acc_q;
        if (en) acc_d = sum;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/aq_alu.sv
// Combinational ALU with a registered multiply-accumulate path.
// Build option: AQ_ALU_ACC_SAT_EN selects a saturating accumulator.
module aq_alu
    import aq_alu_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic    clock,
    input  logic    reset,
    aq_alu_if.slave bus
);
    logic [OUT_W-1:0] a_x, b_x, prod, acc_val, result;
    logic [IN_W-1:0]  nand_v, nor_v, xnor_v;

    assign a_x  = OUT_W'(bus.A);
    assign b_x  = OUT_W'(bus.B);
    assign prod = a_x * b_x;

    // Inversions happen at operand width so the upper result bits stay zero.
    assign nand_v = ~(bus.A & bus.B);
    assign nor_v  = ~(bus.A | bus.B);
    assign xnor_v = ~(bus.A ^ bus.B);

    aq_alu_acc #(.OUT_W(OUT_W)) u_acc (
        .clock  (clock),
        .reset  (reset),
        .en     (bus.Opcode == OP_ACC_MAC),
        .addend (prod),
        .acc_o  (acc_val)
    );

    always_comb begin
        result = '0;
        case (op_e'(bus.Opcode))
            OP_ADD:     result = a_x + b_x;
            OP_SUB:     result = a_x - b_x;
            OP_MUL:     result = prod;
            OP_DIV:     result = (bus.B == '0) ? '1 : a_x / b_x;
            OP_MOD:     result = (bus.B == '0) ? '1 : a_x % b_x;
            OP_AND:     result = OUT_W'(bus.A & bus.B);
            OP_OR:      result = OUT_W'(bus.A | bus.B);
            OP_XOR:     result = OUT_W'(bus.A ^ bus.B);
            OP_NAND:    result = OUT_W'(nand_v);
            OP_NOR:     result = OUT_W'(nor_v);
            OP_XNOR:    result = OUT_W'(xnor_v);
            OP_SHL:     result = a_x << bus.B;
            OP_SHR:     result = a_x >> bus.B;
            OP_CMP:     result = {{(OUT_W-3){1'b0}}, bus.A > bus.B, bus.A == bus.B, bus.A < bus.B};
            OP_ACC_RD:  result = acc_val;
            OP_ACC_MAC: result = acc_val;
        endcase
    end

    assign bus.Output = result;
endmodule

// File: tb/tb_aq_alu.sv
// Scoreboard bench for aq_alu: directed cases plus random traffic against an integer model.
module tb_aq_alu;
    import aq_alu_pkg::*;

    localparam int IN_W  = 2;
    localparam int OUT_W = 8;
    localparam int MOD   = 1 << OUT_W;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    aq_alu_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    aq_alu #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus)
    );

    always #20 clock = ~clock;

    typedef struct {
        int    exp;
        int    a;
        int    b;
        int    op;
        string name;
    } exp_t;

    exp_t sb[$];
    event ev_sample;
    int   n_chk = 0;
    int   n_pass = 0;
    int   model_acc = 0;

    function automatic int next_acc(input int acc, input int p);
        int s;
        s = acc + p;
`ifdef AQ_ALU_ACC_SAT_EN
        return (s > MOD - 1) ? MOD - 1 : s;
`else
        return s % MOD;
`endif
    endfunction

    function automatic int ref_out(input int a, input int b, input int op, input int acc);
        int r;
        int m;
        m = (1 << IN_W) - 1;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a * b;
            3:  r = (b == 0) ? MOD - 1 : a / b;
            4:  r = (b == 0) ? MOD - 1 : a % b;
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = ~(a & b) & m;
            9:  r = ~(a | b) & m;
            10: r = ~(a ^ b) & m;
            11: r = a << b;
            12: r = a >> b;
            13: r = (a > b ? 4 : 0) + (a == b ? 2 : 0) + (a < b ? 1 : 0);
            default: r = acc;
        endcase
        return r & (MOD - 1);
    endfunction

    always @(posedge clock) begin
        if (rst_n && bus.Opcode == 4'hF)
            model_acc = next_acc(model_acc, int'(bus.A) * int'(bus.B));
    end

    // Inputs change on the falling edge; the sample is taken 10 ns later, before the next rising edge.
    task automatic step(input logic r, input int a, input int b, input int op, input string nm);
        exp_t e;
        rst_n      = r;
        bus.A      = IN_W'(a);
        bus.B      = IN_W'(b);
        bus.Opcode = 4'(op);
        if (!r) model_acc = 0;
        e.exp  = ref_out(a, b, op, model_acc);
        e.a    = a;
        e.b    = b;
        e.op   = op;
        e.name = nm;
        sb.push_back(e);
        #10;
        -> ev_sample;
        @(negedge clock);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(ev_sample);
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL no_expected: got=%02h want=<queued entry>", bus.Output);
            end else begin
                e = sb.pop_front();
                if (int'(bus.Output) == e.exp) n_pass++;
                else $display("FAIL %s: a=%0d b=%0d op=%0d got=%02h want=%02h",
                              e.name, e.a, e.b, e.op, bus.Output, e.exp[7:0]);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.A = '0;
        bus.B = '0;
        bus.Opcode = 4'hE;
        @(negedge clock);

        step(0, 0, 0, 14, "rst_acc_rd");
        step(0, 3, 3, 15, "rst_acc_mac");
        step(0, 3, 3, 15, "rst_mac_hold");

        step(1, 3, 2, 0,  "add");
        step(1, 3, 2, 1,  "sub");
        step(1, 1, 3, 1,  "sub_neg");
        step(1, 3, 3, 2,  "mul");
        step(1, 3, 2, 3,  "div");
        step(1, 3, 2, 4,  "mod");
        step(1, 2, 0, 3,  "div_by0");
        step(1, 2, 0, 4,  "mod_by0");
        for (int op = 5; op <= 10; op++) step(1, 2, 3, op, "logic");
        step(1, 0, 0, 8,  "nand_zero");
        step(1, 3, 3, 11, "shl");
        step(1, 2, 1, 12, "shr");
        step(1, 2, 1, 13, "cmp_gt");
        step(1, 1, 1, 13, "cmp_eq");
        step(1, 0, 3, 13, "cmp_lt");

        step(1, 0, 0, 14, "acc_rd0");
        for (int i = 0; i < 3; i++) step(1, 3, 3, 15, "mac3");
        step(1, 3, 3, 14, "acc_rd_1b");
        step(1, 1, 2, 14, "acc_hold1");
        step(1, 2, 1, 14, "acc_hold2");

        step(0, 0, 0, 14, "rst_before_wrap");
        for (int i = 0; i < 29; i++) step(1, 3, 3, 15, "mac29");
        step(1, 0, 0, 14, "acc_wrap");
        step(1, 3, 3, 15, "mac_after_wrap");
        step(1, 2, 3, 15, "mac_after_wrap2");
        step(0, 3, 3, 14, "async_clr");
        step(0, 3, 3, 15, "clr_edge_mac");
        step(0, 3, 3, 15, "clr_edge_mac2");
        step(1, 0, 0, 14, "after_release");

        for (int i = 0; i < 250; i++) begin
            logic r;
            int   op;
            r  = ($urandom_range(0, 24) != 0);
            op = ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 15);
            step(r, $urandom_range(0, 3), $urandom_range(0, 3), op, "random");
        end

        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_drain: got=%0d entries want=0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/aq_alu.md
Name: aq_alu

Overview:
- Small clocked ALU operating on two IN_W-bit unsigned operands under a 4-bit opcode, producing an OUT_W-bit result.
- Opcodes 0000–1101 are purely combinational functions of A and B.
- Opcodes 1110/1111 read and update an internal accumulator register.
- Used as a leaf compute block; the result is valid combinationally, within one settle time of an input change, with no clock edge needed.

Parameters:
- IN_W, 2, operand width (unsigned).
- OUT_W, 8, result and accumulator width; must satisfy OUT_W >= 2*IN_W + 1.

Ports:
- clock  input  1  sole clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- A  input  IN_W  operand A, unsigned.
- B  input  IN_W  operand B, unsigned.
- Opcode  input  4  operation select.
- Output  output  OUT_W  result.

Behaviour:
- Output is combinational from A, B, Opcode and acc; zero cycles of latency.
- All operands are zero-extended to OUT_W before the operation; results are truncated to OUT_W.
- Opcode map:
  - 0000 ADD: A+B.
  - 0001 SUB: A-B, OUT_W-bit two's complement (e.g. 0-1 = 8'hFF).
  - 0010 MUL: A*B.
  - 0011 DIV: A/B, integer quotient; B=0 gives all-ones.
  - 0100 MOD: A%B; B=0 gives all-ones.
  - 0101 AND, 0110 OR, 0111 XOR: bitwise on IN_W bits, zero-extended.
  - 1000 NAND, 1001 NOR, 1010 XNOR: inverted on IN_W bits only, then zero-extended (e.g. NAND 0,0 = 8'h03).
  - 1011 SHL: A << B in OUT_W bits.
  - 1100 SHR: A >> B.
  - 1101 CMP: {zeros, A>B, A==B, A<B} in bits [2:0].
  - 1110 ACC_RD: Output = acc. acc unchanged.
  - 1111 ACC_MAC: Output = acc (current registered value). On each rising clock while Opcode=1111 and reset high: acc <= acc + A*B, wrapping modulo 2^OUT_W.
- acc: OUT_W-bit register. Asynchronously cleared to 0 whenever reset=0, including mid-accumulation. While reset is low, edges do not update acc.
- Output during reset: combinational result with acc=0 (opcodes 1110/1111 give 0).
- Opcode changes between edges: only the Opcode value sampled at the rising edge decides the acc update.
- No X propagation beyond the inputs; every opcode is defined, with no default-case latches.

Optional Feature:
- Macro AQ_ALU_ACC_SAT_EN.
- Defined: ACC_MAC saturates, so acc <= min(acc + A*B, 2^OUT_W-1). Once at all-ones it stays there until reset.
- Undefined: wrap-around modulo 2^OUT_W as above.

Decomposition:
- Package aq_alu_pkg holds:
  - the 4-bit opcode localparams/enum (OP_ADD … OP_ACC_MAC);
  - default IN_W/OUT_W constants.
- One sub-module is natural: aq_alu_acc. It holds the accumulator register, the async active-low clear and the wrap/saturate adder, with inputs clock, reset, en, addend.
- The combinational result mux stays in aq_alu.

Test Plan:
- Arithmetic, checked 10 ns after inputs change with no clock edge:
  - A=3,B=2 op 0000 -> 8'h05.
  - op 0001 -> 8'h01.
  - A=1,B=3 op 0001 -> 8'hFF.
  - A=3,B=3 op 0010 -> 8'h09.
- Division/modulo: A=3,B=2 op 0011 -> 8'h01; op 0100 -> 8'h01. A=2,B=0 op 0011 -> 8'hFF; op 0100 -> 8'hFF.
- Logic/shift/compare:
  - A=2,B=3: op 0101 -> 02; 0110 -> 03; 0111 -> 01; 1000 -> 01; 1001 -> 00; 1010 -> 02.
  - A=3,B=3 op 1011 -> 8'h18.
  - A=2,B=1 op 1100 -> 01; A=2,B=1 op 1101 -> 8'h04.
- Accumulator:
  - Reset low then high.
  - Op 1110 -> 00.
  - Op 1111 with A=3,B=3 for 3 rising edges, then op 1110 -> 8'h1B.
  - Holding op 1110 across edges leaves acc unchanged.
- Wrap/saturate: op 1111, A=3,B=3 for 29 edges -> acc = 261 mod 256 = 8'h05. With AQ_ALU_ACC_SAT_EN -> 8'hFF.
- Async reset mid-operation: during accumulation, pull reset low between clock edges -> Output (op 1110) reads 00 immediately without a clock edge. Edges while reset is low leave it at 00.
